// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single memory-controller port.
// Port 1 (data cache) has priority; port 0 (fetch) is forced through after MAX_WAIT lost grants.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no transaction outstanding, arbitrate between requesters
// ISSUE     | latched request presented to memory, waiting for i_mem_ready
// WAIT_RESP | request accepted by memory, waiting for i_mem_rvalid
module mem_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int LINE_W   = 128,
  parameter int MAX_WAIT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,

  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [XLEN-1:0]   i_req0_addr,
  input  logic              i_req0_rw,
  input  logic [LINE_W-1:0] i_req0_wdata,
  output logic              o_rsp0_valid,
  output logic [LINE_W-1:0] o_rsp0_rdata,

  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [XLEN-1:0]   i_req1_addr,
  input  logic              i_req1_rw,
  input  logic [LINE_W-1:0] i_req1_wdata,
  output logic              o_rsp1_valid,
  output logic [LINE_W-1:0] o_rsp1_rdata,

  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic              o_mem_rw,
  output logic [LINE_W-1:0] o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [LINE_W-1:0] i_mem_rdata,

  output logic              o_busy,
  output logic              o_owner
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic starved;
  logic grant0;
  logic grant1;

  assign starved = (cnt_q == CNT_W'(MAX_WAIT));

  // Port 1 yields only when port 0 is actually waiting and has hit the limit,
  // so a saturated counter never blocks a lone port-1 request.
  assign grant1 = i_req1_valid && !(i_req0_valid && starved);
  assign grant0 = i_req0_valid && !grant1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_rsp0_valid = 1'b0;
    o_rsp1_valid = 1'b0;
    o_mem_valid  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant1) begin
          o_req1_ready = 1'b1;
          owner_d      = 1'b1;
          addr_d       = i_req1_addr;
          rw_d         = i_req1_rw;
          wdata_d      = i_req1_wdata;
          state_d      = ISSUE;
          if (i_req0_valid && !starved)
            cnt_d = cnt_q + CNT_W'(1);
        end else if (grant0) begin
          o_req0_ready = 1'b1;
          owner_d      = 1'b0;
          addr_d       = i_req0_addr;
          rw_d         = i_req0_rw;
          wdata_d      = i_req0_wdata;
          state_d      = ISSUE;
          cnt_d        = '0;
        end
      end
      ISSUE: begin
        o_mem_valid = 1'b1;
        if (i_mem_ready)
          state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (i_mem_rvalid) begin
          o_rsp0_valid = !owner_q;
          o_rsp1_valid = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rsp0_rdata = i_mem_rdata;
  assign o_rsp1_rdata = i_mem_rdata;
  assign o_mem_addr   = addr_q;
  assign o_mem_rw     = rw_q;
  assign o_mem_wdata  = wdata_q;
  assign o_busy       = (state_q != IDLE);
  assign o_owner      = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic         i_clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_req0_valid = 1'b0, i_req1_valid = 1'b0;
  logic         o_req0_ready, o_req1_ready;
  logic [31:0]  i_req0_addr = '0, i_req1_addr = '0;
  logic         i_req0_rw = 1'b0, i_req1_rw = 1'b0;
  logic [127:0] i_req0_wdata = '0, i_req1_wdata = '0;
  logic         o_rsp0_valid, o_rsp1_valid;
  logic [127:0] o_rsp0_rdata, o_rsp1_rdata;
  logic         o_mem_valid;
  logic         i_mem_ready = 1'b0;
  logic [31:0]  o_mem_addr;
  logic         o_mem_rw;
  logic [127:0] o_mem_wdata;
  logic         i_mem_rvalid = 1'b0;
  logic [127:0] i_mem_rdata = '0;
  logic         o_busy, o_owner;

  int tests = 0;
  int fails = 0;
  int n_rsp0 = 0;
  int n_rsp1 = 0;

  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] DB   = {4{32'hDEADBEEF}};

  mem_port_arbiter #(.XLEN(32), .LINE_W(128), .MAX_WAIT(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_addr(i_req0_addr),
    .i_req0_rw(i_req0_rw), .i_req0_wdata(i_req0_wdata), .o_rsp0_valid(o_rsp0_valid),
    .o_rsp0_rdata(o_rsp0_rdata),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_addr(i_req1_addr),
    .i_req1_rw(i_req1_rw), .i_req1_wdata(i_req1_wdata), .o_rsp1_valid(o_rsp1_valid),
    .o_rsp1_rdata(o_rsp1_rdata),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_rw(o_mem_rw), .o_mem_wdata(o_mem_wdata), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_busy(o_busy), .o_owner(o_owner)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_rsp0_valid) n_rsp0 <= n_rsp0 + 1;
    if (o_rsp1_valid) n_rsp1 <= n_rsp1 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
  endtask

  // Entered 1 time unit after a rising edge with the requests already driven;
  // returns 1 time unit after the edge that puts the arbiter back in IDLE.
  task automatic serve(input logic own, input logic [31:0] addr, input logic rw,
                       input logic [127:0] wd, input logic [127:0] rd,
                       input logic drop, input logic scramble);
    @(negedge i_clk);
    chk_b("ready_winner", own ? o_req1_ready : o_req0_ready, 1'b1);
    chk_b("ready_loser",  own ? o_req0_ready : o_req1_ready, 1'b0);
    @(posedge i_clk); #1;
    if (drop) begin
      if (own) i_req1_valid = 1'b0; else i_req0_valid = 1'b0;
    end
    if (scramble) begin
      if (own) begin i_req1_addr = ~addr; i_req1_wdata = ~wd; end
      else     begin i_req0_addr = ~addr; i_req0_wdata = ~wd; end
    end
    @(negedge i_clk);
    chk_b("mem_valid_issue", o_mem_valid, 1'b1);
    chk_v("mem_addr", 128'(o_mem_addr), 128'(addr));
    chk_b("mem_rw", o_mem_rw, rw);
    chk_v("mem_wdata", o_mem_wdata, wd);
    chk_b("owner", o_owner, own);
    chk_b("busy_issue", o_busy, 1'b1);
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1 i_mem_ready = 1'b0;
    @(negedge i_clk);
    chk_b("mem_valid_wait", o_mem_valid, 1'b0);
    chk_v("mem_addr_hold", 128'(o_mem_addr), 128'(addr));
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = rd;
    #1;
    chk_b("rsp_owner_valid", own ? o_rsp1_valid : o_rsp0_valid, 1'b1);
    chk_b("rsp_other_valid", own ? o_rsp0_valid : o_rsp1_valid, 1'b0);
    chk_v("rsp_rdata", own ? o_rsp1_rdata : o_rsp0_rdata, rd);
    @(posedge i_clk); #1 i_mem_rvalid = 1'b0;
    chk_b("busy_done", o_busy, 1'b0);
  endtask

  initial begin
    int r0, r1;
    // reset state
    #2;
    chk_b("rst_busy", o_busy, 1'b0);
    chk_b("rst_owner", o_owner, 1'b0);
    chk_b("rst_mem_valid", o_mem_valid, 1'b0);
    chk_v("rst_addr", 128'(o_mem_addr), 128'h0);
    chk_b("rst_ready0", o_req0_ready, 1'b0);
    chk_b("rst_ready1", o_req1_ready, 1'b0);
    do_reset();

    // single port-0 read, slow memory
    i_req0_valid = 1'b1; i_req0_addr = 32'h0000_1000; i_req0_rw = 1'b0;
    @(negedge i_clk);
    chk_b("t1_ready0", o_req0_ready, 1'b1);
    chk_b("t1_ready1", o_req1_ready, 1'b0);
    @(posedge i_clk); #1 i_req0_valid = 1'b0;
    @(negedge i_clk);
    chk_b("t1_mem_valid", o_mem_valid, 1'b1);
    chk_v("t1_mem_addr", 128'(o_mem_addr), 128'h1000);
    chk_b("t1_mem_rw", o_mem_rw, 1'b0);
    chk_b("t1_ready0_again", o_req0_ready, 1'b0);
    i_mem_rvalid = 1'b1; i_mem_rdata = '1;
    #1 chk_b("t1_rvalid_in_issue", o_rsp0_valid, 1'b0);
    i_mem_rvalid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk_b("t1_mem_valid_2", o_mem_valid, 1'b1);
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1 i_mem_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk_b("t1_no_early_rsp", o_rsp0_valid, 1'b0);
    chk_b("t1_busy_wait", o_busy, 1'b1);
    i_mem_rvalid = 1'b1; i_mem_rdata = A5;
    #1;
    chk_b("t1_rsp0_valid", o_rsp0_valid, 1'b1);
    chk_v("t1_rsp0_rdata", o_rsp0_rdata, A5);
    chk_b("t1_rsp1_valid", o_rsp1_valid, 1'b0);
    @(posedge i_clk); #1 i_mem_rvalid = 1'b0;
    chk_b("t1_busy_done", o_busy, 1'b0);
    @(posedge i_clk); #1;
    chk_v("t1_rsp0_count", 128'(n_rsp0), 128'd1);
    chk_v("t1_rsp1_count", 128'(n_rsp1), 128'd0);

    // simultaneous requests from reset: port 1 first
    do_reset();
    i_req0_valid = 1'b1; i_req0_addr = 32'h100; i_req0_rw = 1'b0; i_req0_wdata = '0;
    i_req1_valid = 1'b1; i_req1_addr = 32'h200; i_req1_rw = 1'b0; i_req1_wdata = '0;
    serve(1'b1, 32'h200, 1'b0, '0, 128'h11, 1'b1, 1'b0);
    serve(1'b0, 32'h100, 1'b0, '0, 128'h22, 1'b1, 1'b0);

    // starvation limit: four port-1 grants then port 0 (counter started at 0)
    i_req0_valid = 1'b1; i_req0_addr = 32'h300;
    i_req1_valid = 1'b1; i_req1_addr = 32'h400;
    for (int k = 0; k < 4; k++)
      serve(1'b1, 32'h400, 1'b0, '0, 128'(k + 32'h30), 1'b0, 1'b0);
    serve(1'b0, 32'h300, 1'b0, '0, 128'h55, 1'b1, 1'b0);
    serve(1'b1, 32'h400, 1'b0, '0, 128'h66, 1'b1, 1'b0);

    // port-1 write, requester changes inputs while the transaction is in ISSUE
    i_req1_valid = 1'b1; i_req1_addr = 32'h500; i_req1_rw = 1'b1; i_req1_wdata = DB;
    serve(1'b1, 32'h500, 1'b1, DB, 128'h0, 1'b1, 1'b1);
    i_req1_rw = 1'b0;

    // port 0 pulses valid while port 1 owns the port
    r0 = n_rsp0;
    i_req1_valid = 1'b1; i_req1_addr = 32'h600; i_req1_wdata = '0;
    @(negedge i_clk);
    chk_b("t5_ready1", o_req1_ready, 1'b1);
    @(posedge i_clk); #1;
    i_req1_valid = 1'b0;
    i_req0_valid = 1'b1; i_req0_addr = 32'h0BAD;
    @(negedge i_clk);
    chk_b("t5_ready0_in_issue", o_req0_ready, 1'b0);
    chk_v("t5_mem_addr", 128'(o_mem_addr), 128'h600);
    chk_b("t5_owner", o_owner, 1'b1);
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1;
    i_mem_ready = 1'b0; i_req0_valid = 1'b0;
    @(negedge i_clk);
    i_mem_rvalid = 1'b1; i_mem_rdata = 128'h77;
    #1 chk_b("t5_rsp1", o_rsp1_valid, 1'b1);
    chk_b("t5_rsp0", o_rsp0_valid, 1'b0);
    @(posedge i_clk); #1 i_mem_rvalid = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      chk_b("t5_idle_busy", o_busy, 1'b0);
      chk_b("t5_idle_mem_valid", o_mem_valid, 1'b0);
    end
    chk_v("t5_no_rsp0", 128'(n_rsp0), 128'(r0));

    // reset asserted during WAIT_RESP
    r0 = n_rsp0; r1 = n_rsp1;
    @(posedge i_clk); #1;
    i_req1_valid = 1'b1; i_req1_addr = 32'h700;
    @(posedge i_clk); #1 i_req1_valid = 1'b0;
    @(negedge i_clk) i_mem_ready = 1'b1;
    @(posedge i_clk); #1 i_mem_ready = 1'b0;
    @(negedge i_clk);
    chk_b("t6_busy_before", o_busy, 1'b1);
    #1 i_reset_n = 1'b0;
    #1;
    chk_b("t6_busy_async", o_busy, 1'b0);
    chk_b("t6_mem_valid_async", o_mem_valid, 1'b0);
    chk_b("t6_owner_async", o_owner, 1'b0);
    i_mem_rvalid = 1'b1;
    #1 chk_b("t6_rsp1_in_reset", o_rsp1_valid, 1'b0);
    @(posedge i_clk); #1 i_mem_rvalid = 1'b0;
    @(posedge i_clk); #1 i_reset_n = 1'b1;
    chk_v("t6_rsp0_count", 128'(n_rsp0), 128'(r0));
    chk_v("t6_rsp1_count", 128'(n_rsp1), 128'(r1));
    i_req0_valid = 1'b1; i_req0_addr = 32'h800;
    serve(1'b0, 32'h800, 1'b0, '0, 128'h88, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
